pe_v8_drain: RTL and testbench
==============================

PE_V8_DRAIN -- requirements
Module: pe_v8_drain

Interface
REQ-001 The block SHALL have the following parameters, one per line (name, default, meaning).
- REG_WIDTH, 16, element width; matches PE accumulator width.
- VECTOR, 8, lanes per result vector.
- DEPTH, 4, vector FIFO entries; power of 2, minimum 2.

REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning).
- clk, input, 1, the single clock; every register updates on the rising edge.
- rst_n, input, 1, reset; synchronous, active-low.
- in_valid, input, 1, c_in carries a completed result vector this cycle.
- c_in, input, REG_WIDTH x VECTOR (unpacked array [VECTOR-1:0]), result vector from the last PE stage.
- out_data, output, REG_WIDTH, serialized result element.
- out_lane, output, $clog2(VECTOR), lane index of out_data.
- out_valid, output, 1, out_data and out_lane are valid.
- out_ready, input, 1, consumer accepts out_data.
- out_last, output, 1, out_data is lane VECTOR-1; present only when DRAIN_LAST_EN is defined.
- full, output, 1, the FIFO holds DEPTH vectors.
- empty, output, 1, the FIFO holds 0 vectors.
- count, output, $clog2(DEPTH)+1, number of vectors stored.
- overflow, output, 1, sticky flag: a vector was dropped.
- clr_ovf, input, 1, clears overflow.

Function
REQ-003 The block SHALL store each c_in vector whole into a DEPTH-entry FIFO on a clock edge where in_valid=1 and the write is accepted.
REQ-004 A write SHALL be accepted when full=0, or when full=1 and the final-lane pop (REQ-008) occurs in the same cycle.
REQ-005 A write that is not accepted SHALL drop the vector, set overflow to 1, and leave the FIFO contents and count unchanged.
REQ-006 The block SHALL serialize the head vector one element per handshake, in lane order 0 to VECTOR-1.
- out_data equals head[out_lane].
- out_valid equals !empty.
REQ-007 A transfer SHALL occur on a clock edge with out_valid=1 and out_ready=1; each transfer increments out_lane by 1.
REQ-008 The transfer at out_lane=VECTOR-1 SHALL pop the head vector and return out_lane to 0.
REQ-009 While out_valid=1 and out_ready=0, out_data and out_lane SHALL hold stable.
REQ-010 Latency: a vector written into an empty FIFO at edge N SHALL present lane 0 with out_valid=1 in the cycle after edge N.
REQ-011 The serializer control SHALL be a two-state FSM.
- IDLE (empty=1) moves to STREAM on an accepted write.
- STREAM moves to IDLE on the final-lane pop when no other vector is stored and none is written that cycle; otherwise it stays in STREAM.
REQ-012 When a write and a final-lane pop occur on the same edge, count SHALL remain unchanged.
REQ-013 Read and write pointers SHALL wrap modulo DEPTH.
REQ-014 full SHALL equal (count==DEPTH), and empty SHALL equal (count==0).
REQ-015 clr_ovf=1 SHALL clear overflow on the next edge; if a drop occurs on the same edge, set SHALL win.
REQ-016 out_ready SHALL be ignored while out_valid=0.

Reset
REQ-017 On an edge with rst_n=0 the block SHALL reset as follows:
- pointers = 0, count = 0, out_lane = 0;
- state = IDLE, out_valid = 0, full = 0, empty = 1, overflow = 0, out_last = 0;
- in_valid is ignored on that edge.
REQ-018 Reset asserted mid-stream SHALL discard all stored vectors and any partially drained vector; FIFO storage contents are not reset.

Configuration
REQ-019 The macro DRAIN_LAST_EN SHALL select out_last support.
- Defined: the out_last port exists and equals out_valid && (out_lane==VECTOR-1).
- Undefined: the port and its logic are absent; all other behaviour is identical.

Verification
REQ-020 The bench SHALL cover the following directed scenarios.
- Single vector: reset, write c_in={7,6,5,4,3,2,1,0} (lane7..lane0), out_ready=1 -> out_data 0..7 on lanes 0..7 over 8 consecutive cycles, first at 1 cycle after the write; out_last high on lane 7 only; empty=1 afterwards.
- Backpressure: out_ready=0 for 5 cycles at lane 3 -> out_data=3 and out_lane=3 held stable; the stream resumes at lane 3.
- Overflow: out_ready=0, write 5 vectors with DEPTH=4 -> full=1 after the 4th, 5th vector dropped, overflow=1, count=4; then clr_ovf -> overflow=0.
- Simultaneous write and pop at full: count=4, lane 7 handshake plus in_valid on the same edge -> write accepted, count stays 4, overflow stays 0.
- Wrap-around: stream 10 vectors with continuous out_ready -> all 80 elements in order; pointers wrap twice; no overflow.
- Mid-stream reset: rst_n=0 at lane 4 of a vector with count=3 -> next cycle out_valid=0, count=0, out_lane=0, empty=1.

Source files
------------

// File: rtl/pe_v8_drain.sv
// Result-vector drain: buffers whole PE result vectors in a FIFO and streams them out one lane per handshake.
// Optional out_last port is enabled by defining DRAIN_LAST_EN.
module pe_v8_drain #(
    parameter int unsigned REG_WIDTH = 16,
    parameter int unsigned VECTOR    = 8,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [REG_WIDTH-1:0]         c_in [VECTOR-1:0],
    output logic [REG_WIDTH-1:0]         out_data,
    output logic [$clog2(VECTOR)-1:0]    out_lane,
    output logic                         out_valid,
    input  logic                         out_ready,
`ifdef DRAIN_LAST_EN
    output logic                         out_last,
`endif
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         overflow,
    input  logic                         clr_ovf
);

    localparam int unsigned LANE_W = $clog2(VECTOR);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                 state;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count_nxt;
    logic [REG_WIDTH-1:0]   mem [DEPTH][VECTOR];

    logic xfer;
    logic last_lane;
    logic pop;
    logic wr_ok;
    logic drop;

    assign out_valid = (state == STREAM);
    assign out_data  = mem[rd_ptr][out_lane];
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);

    // A full FIFO still accepts a write when the head vector retires on the same edge.
    assign xfer      = out_valid && out_ready;
    assign last_lane = (out_lane == LANE_W'(VECTOR - 1));
    assign pop       = xfer && last_lane;
    assign wr_ok     = in_valid && (!full || pop);
    assign drop      = in_valid && !wr_ok;

`ifdef DRAIN_LAST_EN
    assign out_last  = out_valid && last_lane;
`endif

    always_comb begin
        count_nxt = count;
        if (wr_ok && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (!wr_ok && pop) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    // Control, pointers, lane counter and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out_lane <= '0;
            overflow <= 1'b0;
        end else begin
            count <= count_nxt;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (xfer) begin
                out_lane <= last_lane ? '0 : out_lane + LANE_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
            case (state)
                IDLE:    if (wr_ok) state <= STREAM;
                STREAM:  if (pop && (count == CNT_W'(1)) && !wr_ok) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Vector storage; not reset, the pointers define what is live.
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok) begin
            for (int i = 0; i < int'(VECTOR); i++) begin
                mem[wr_ptr][i] <= c_in[i];
            end
        end
    end

endmodule

// File: tb/tb_pe_v8_drain.sv
// Directed self-checking bench for pe_v8_drain with default parameters.
module tb_pe_v8_drain;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] c_in [7:0];
    logic [15:0] out_data;
    logic [2:0]  out_lane;
    logic        out_valid;
    logic        out_ready;
`ifdef DRAIN_LAST_EN
    logic        out_last;
`endif
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic        overflow;
    logic        clr_ovf;

    int errors = 0;
    int checks = 0;

    pe_v8_drain dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .c_in      (c_in),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef DRAIN_LAST_EN
        .out_last  (out_last),
`endif
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int base);
        for (int i = 0; i < 8; i++) c_in[i] = 16'(base + i);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
        set_vec(0);
        tick(); tick();
        rst_n = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags empty=%b full=%b exp 1/0", empty, full); end
        checks++; if (count !== 3'd0 || out_lane !== 3'd0) begin errors++; $display("FAIL reset_cnt count=%0d lane=%0d exp 0/0", count, out_lane); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
`ifdef DRAIN_LAST_EN
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", out_last); end
`endif
    endtask

    task automatic test_single();
        set_vec(0); in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_lane !== 3'(i) || out_data !== 16'(i)) begin
                errors++; $display("FAIL single_lane%0d valid=%b lane=%0d data=%0d exp 1/%0d/%0d", i, out_valid, out_lane, out_data, i, i);
            end
`ifdef DRAIN_LAST_EN
            checks++; if (out_last !== (i == 7)) begin errors++; $display("FAIL single_last%0d got=%b exp=%b", i, out_last, i == 7); end
`endif
            tick();
        end
        checks++; if (empty !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL single_empty empty=%b valid=%b exp 1/0", empty, out_valid); end
    endtask

    task automatic test_backpressure();
        set_vec(10); in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_lane !== 3'd3 || out_data !== 16'd13) begin
                errors++; $display("FAIL bp_hold%0d valid=%b lane=%0d data=%0d exp 1/3/13", c, out_valid, out_lane, out_data);
            end
        end
        out_ready = 1'b1;
        for (int i = 3; i < 8; i++) begin
            checks++;
            if (out_lane !== 3'(i) || out_data !== 16'(10 + i)) begin
                errors++; $display("FAIL bp_resume%0d lane=%0d data=%0d exp %0d/%0d", i, out_lane, out_data, i, 10 + i);
            end
            tick();
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL bp_empty got=%b exp=1", empty); end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int v = 0; v < 5; v++) begin
            set_vec(100 * (v + 1)); in_valid = 1'b1;
            tick();
            if (v == 3) begin
                checks++; if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b0) begin
                    errors++; $display("FAIL ovf_full full=%b count=%0d ovf=%b exp 1/4/0", full, count, overflow); end
            end
        end
        in_valid = 1'b0;
        checks++; if (overflow !== 1'b1 || count !== 3'd4 || full !== 1'b1) begin
            errors++; $display("FAIL ovf_drop ovf=%b count=%0d full=%b exp 1/4/1", overflow, count, full); end
        checks++; if (out_data !== 16'd100 || out_lane !== 3'd0) begin
            errors++; $display("FAIL ovf_head data=%0d lane=%0d exp 100/0", out_data, out_lane); end
        set_vec(900); in_valid = 1'b1; clr_ovf = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_setwins got=%b exp=1", overflow); end
        tick();
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0 || count !== 3'd4) begin
            errors++; $display("FAIL ovf_clear ovf=%b count=%0d exp 0/4", overflow, count); end
    endtask

    task automatic test_simul_full();
        int bases [4] = '{200, 300, 400, 600};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        checks++; if (out_lane !== 3'd7 || out_data !== 16'd107 || count !== 3'd4) begin
            errors++; $display("FAIL simul_pre lane=%0d data=%0d count=%0d exp 7/107/4", out_lane, out_data, count); end
        set_vec(600); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (count !== 3'd4 || overflow !== 1'b0 || full !== 1'b1) begin
            errors++; $display("FAIL simul_cnt count=%0d ovf=%b full=%b exp 4/0/1", count, overflow, full); end
        checks++; if (out_lane !== 3'd0 || out_data !== 16'd200) begin
            errors++; $display("FAIL simul_head lane=%0d data=%0d exp 0/200", out_lane, out_data); end
        for (int v = 0; v < 4; v++) begin
            for (int l = 0; l < 8; l++) begin
                checks++;
                if (out_valid !== 1'b1 || out_lane !== 3'(l) || out_data !== 16'(bases[v] + l)) begin
                    errors++; $display("FAIL simul_drain v%0d l%0d valid=%b lane=%0d data=%0d exp %0d", v, l, out_valid, out_lane, out_data, bases[v] + l);
                end
                tick();
            end
        end
        checks++; if (empty !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL simul_empty empty=%b valid=%b", empty, out_valid); end
    endtask

    task automatic test_wrap();
        int wv = 0;
        int rv = 0;
        int rl = 0;
        int cyc = 0;
        out_ready = 1'b1;
        while (rv < 10 && cyc < 400) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (out_lane !== 3'(rl) || out_data !== 16'(1000 + 16 * rv + rl)) begin
                    errors++; $display("FAIL wrap_elem v%0d l%0d lane=%0d data=%0d exp %0d", rv, rl, out_lane, out_data, 1000 + 16 * rv + rl);
                end
                if (rl == 7) begin rl = 0; rv++; end else rl++;
            end
            if (wv < 10 && full === 1'b0) begin
                set_vec(1000 + 16 * wv); in_valid = 1'b1; wv++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (rv != 10) begin errors++; $display("FAIL wrap_timeout vectors=%0d exp 10", rv); end
        checks++; if (overflow !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL wrap_end ovf=%b empty=%b exp 0/1", overflow, empty); end
    endtask

    task automatic test_midreset();
        out_ready = 1'b0;
        for (int v = 0; v < 3; v++) begin
            set_vec(2000 + 100 * v); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (count !== 3'd3 || out_lane !== 3'd4 || out_data !== 16'd2004) begin
            errors++; $display("FAIL mrst_pre count=%0d lane=%0d data=%0d exp 3/4/2004", count, out_lane, out_data); end
        rst_n = 1'b0; set_vec(3000); in_valid = 1'b1;
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || count !== 3'd0 || out_lane !== 3'd0 || empty !== 1'b1) begin
            errors++; $display("FAIL mrst_post valid=%b count=%0d lane=%0d empty=%b exp 0/0/0/1", out_valid, count, out_lane, empty); end
        tick();
        checks++; if (out_valid !== 1'b0 || empty !== 1'b1) begin
            errors++; $display("FAIL mrst_ignored valid=%b empty=%b exp 0/1", out_valid, empty); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_simul_full();
        test_wrap();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
